pb_varint_stream_dec: RTL
=========================

PB_VARINT_STREAM_DEC -- requirements
Module: pb_varint_stream_dec

Interface
REQ-001 SHALL have parameter VALUE_W, default 64, decoded value width (legal 8..64).
REQ-002 SHALL have parameter MAX_BYTES, default (VALUE_W+6)/7, maximum encoded bytes per varint before overlong error.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  input byte valid; in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-005 in_data  in  8  encoded byte; in_last  in  1  byte is final byte of the enclosing message.
REQ-006 out_valid  out  1  decoded result valid; out_ready  in  1  consumer accepts.
REQ-007 out_value  out  VALUE_W  decoded value; out_field  out  VALUE_W-3  out_value>>3; out_wire_type  out  3  out_value[2:0].
REQ-008 out_nbytes  out  $clog2(MAX_BYTES+1)  bytes consumed for this result; out_err  out  2  pb_varint_err_e code.

Function
REQ-009 Byte k (0-based) SHALL contribute in_data[6:0] to value bits [7k+6:7k]; bits at positions >= VALUE_W SHALL be dropped.
REQ-010 A varint SHALL terminate on an accepted byte with in_data[7]==0.
REQ-011 States: ACC (accumulating), HOLD (result held), DISCARD (skip to resync).
REQ-012 ACC: terminating byte accepted in cycle N -> out_valid=1 in cycle N+1, state HOLD, accumulator cleared.
REQ-013 HOLD: outputs SHALL stay stable until out_valid & out_ready; in_ready = out_ready.
REQ-014 On HOLD handshake, next state SHALL be DISCARD if the result was ERR_OVERLONG, else ACC; a byte accepted in that same cycle SHALL be processed under the next state.
REQ-015 ERR_RANGE (1): terminating byte with any dropped bit nonzero; value is truncated low VALUE_W bits.
REQ-016 ERR_OVERLONG (2): byte index MAX_BYTES-1 accepted with in_data[7]==1; emit partial value, then DISCARD.
REQ-017 ERR_TRUNC (3): byte with in_data[7]==1 and in_last==1 in ACC; emit partial value, return to ACC.
REQ-018 Error priority SHALL be TRUNC > OVERLONG > RANGE; ERR_OK = 0.
REQ-019 DISCARD: in_ready=1; bytes consumed with no output; exit to ACC after accepting a byte with in_data[7]==0 or in_last==1.
REQ-020 ACC and DISCARD SHALL hold in_ready=1; sustained throughput one byte per cycle, no bubble between varints when out_ready=1.

Reset
REQ-021 rst SHALL force state ACC, accumulator 0, byte count 0, out_valid=0, out_value=0, out_nbytes=0, out_err=0; in_ready=1 in the first cycle after reset.
REQ-022 Reset mid-varint or in HOLD SHALL drop the partial/held result with no output.

Configuration
REQ-023 Macro PB_VARINT_ZIGZAG_EN: when defined, SHALL add port in_zigzag  in  1, sampled on byte 0; if set, out_value = (v>>1) ^ -(v&1) (sint decode); out_field/out_wire_type derive from the raw value.
REQ-024 Without PB_VARINT_ZIGZAG_EN, in_zigzag SHALL not exist and out_value is always raw.

Structure
REQ-025 pb_pkg SHALL hold pb_varint_err_e (OK, RANGE, OVERLONG, TRUNC) and PB_MAX_VARINT_BYTES = 10.
REQ-026 No sub-module; FSM, accumulator, zigzag inline.

Verification
REQ-027 Bytes 0x96,0x01 -> out_value=150, out_nbytes=2, out_err=OK, out_valid the cycle after 0x01.
REQ-028 Byte 0x08 -> out_field=1, out_wire_type=0; out_ready low 5 cycles -> in_ready=0, outputs stable.
REQ-029 VALUE_W=32: FF,FF,FF,FF,0F -> 0xFFFFFFFF OK; FF,FF,FF,FF,1F -> 0xFFFFFFFF ERR_RANGE.
REQ-030 Ten 0xFF then 0xFF,0x01,0x05 -> one ERR_OVERLONG result (nbytes=10), then 5 with OK, nbytes=1.
REQ-031 0x80 with in_last=1 -> value 0, ERR_TRUNC; next 0x01 -> 1 OK.
REQ-032 With PB_VARINT_ZIGZAG_EN, in_zigzag=1: 0x03 -> -2; 0x04 -> 2; reset asserted after 0x96 -> no output.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types for the protobuf varint stream decoder: error codes, FSM states
// and the protobuf-wide varint length limit.
package pb_pkg;

  localparam int PB_MAX_VARINT_BYTES = 10;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_OVERLONG = 2'd2,
    ERR_TRUNC    = 2'd3
  } pb_varint_err_e;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } pb_varint_state_e;

endpackage

// File: rtl/pb_varint_stream_dec_if.sv
// Byte-in / result-out handshake bundle for pb_varint_stream_dec.
// in_zigzag only exists when PB_VARINT_ZIGZAG_EN is defined.
interface pb_varint_stream_dec_if
  import pb_pkg::*;
#(
  parameter int VALUE_W   = 64,
  parameter int MAX_BYTES = (VALUE_W + 6) / 7
);
  localparam int NB_W = $clog2(MAX_BYTES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_last;
`ifdef PB_VARINT_ZIGZAG_EN
  logic                 in_zigzag;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [VALUE_W-1:0]   out_value;
  logic [VALUE_W-4:0]   out_field;
  logic [2:0]           out_wire_type;
  logic [NB_W-1:0]      out_nbytes;
  pb_varint_err_e       out_err;

  modport slave (
`ifdef PB_VARINT_ZIGZAG_EN
    input  in_zigzag,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_field, out_wire_type, out_nbytes, out_err
  );

  modport master (
`ifdef PB_VARINT_ZIGZAG_EN
    output in_zigzag,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_field, out_wire_type, out_nbytes, out_err
  );

endinterface

// File: rtl/pb_varint_stream_dec.sv
// Streaming protobuf varint decoder, one byte per cycle, with error flagging.
// Optional sint (zigzag) decode under macro PB_VARINT_ZIGZAG_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_ACC     | accumulating 7-bit groups of the current varint
// ST_HOLD    | result registered on out_*, waiting for out_ready
// ST_DISCARD | after an overlong varint, skip bytes until a resync point
module pb_varint_stream_dec
  import pb_pkg::*;
#(
  parameter int VALUE_W   = 64,
  parameter int MAX_BYTES = (VALUE_W + 6) / 7
) (
  input  logic                    clk,
  input  logic                    rst,
  pb_varint_stream_dec_if.slave   bus
);

  localparam int NB_W   = $clog2(MAX_BYTES + 1);
  localparam int WIDE_W = VALUE_W + 7 * MAX_BYTES;

  pb_varint_state_e   state_q, state_d, proc_state;
  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [NB_W-1:0]    cnt_q, cnt_d;
  logic               range_q, range_d;
  logic               zz_q, zz_d;
  logic               out_valid_q, out_valid_d;
  logic [VALUE_W-1:0] out_raw_q, out_raw_d;
  logic [VALUE_W-1:0] out_value_q, out_value_d;
  logic [NB_W-1:0]    out_nbytes_q, out_nbytes_d;
  pb_varint_err_e     out_err_q, out_err_d;

  logic               in_ready, accept, handshake, emit, drop_nz, zz_use;
  logic [WIDE_W-1:0]  shifted;
  logic [VALUE_W-1:0] acc_nxt;
  pb_varint_err_e     err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      range_q      <= 1'b0;
      zz_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_raw_q    <= '0;
      out_value_q  <= '0;
      out_nbytes_q <= '0;
      out_err_q    <= ERR_OK;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      range_q      <= range_d;
      zz_q         <= zz_d;
      out_valid_q  <= out_valid_d;
      out_raw_q    <= out_raw_d;
      out_value_q  <= out_value_d;
      out_nbytes_q <= out_nbytes_d;
      out_err_q    <= out_err_d;
    end
  end

  // A byte accepted during the HOLD handshake is decoded under the state being entered.
  always_comb begin
    handshake  = out_valid_q & bus.out_ready;
    in_ready   = (state_q == ST_HOLD) ? bus.out_ready : 1'b1;
    accept     = bus.in_valid & in_ready;
    proc_state = state_q;
    if (state_q == ST_HOLD && handshake)
      proc_state = (out_err_q == ERR_OVERLONG) ? ST_DISCARD : ST_ACC;

    shifted = WIDE_W'(bus.in_data[6:0]) << (7 * cnt_q);
    acc_nxt = acc_q | shifted[VALUE_W-1:0];
    drop_nz = range_q | (|shifted[WIDE_W-1:VALUE_W]);
`ifdef PB_VARINT_ZIGZAG_EN
    zz_use  = (cnt_q == '0) ? bus.in_zigzag : zz_q;
`else
    zz_use  = 1'b0;
`endif

    emit    = 1'b0;
    err_nxt = ERR_OK;
    if (accept && proc_state == ST_ACC) begin
      if (bus.in_data[7] && bus.in_last) begin
        emit    = 1'b1;
        err_nxt = ERR_TRUNC;
      end else if (bus.in_data[7] && cnt_q == NB_W'(MAX_BYTES - 1)) begin
        emit    = 1'b1;
        err_nxt = ERR_OVERLONG;
      end else if (!bus.in_data[7]) begin
        emit    = 1'b1;
        err_nxt = drop_nz ? ERR_RANGE : ERR_OK;
      end
    end
  end

  always_comb begin
    state_d = proc_state;
    if (accept) begin
      case (proc_state)
        ST_ACC:     if (emit) state_d = ST_HOLD;
        ST_DISCARD: if (!bus.in_data[7] || bus.in_last) state_d = ST_ACC;
        default:    ;
      endcase
    end
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    range_d      = range_q;
    zz_d         = zz_q;
    out_valid_d  = out_valid_q & ~handshake;
    out_raw_d    = out_raw_q;
    out_value_d  = out_value_q;
    out_nbytes_d = out_nbytes_q;
    out_err_d    = out_err_q;
    if (accept && proc_state == ST_ACC) begin
      if (emit) begin
        acc_d        = '0;
        cnt_d        = '0;
        range_d      = 1'b0;
        zz_d         = 1'b0;
        out_valid_d  = 1'b1;
        out_raw_d    = acc_nxt;
        out_value_d  = zz_use ? ((acc_nxt >> 1) ^ {VALUE_W{acc_nxt[0]}}) : acc_nxt;
        out_nbytes_d = cnt_q + NB_W'(1);
        out_err_d    = err_nxt;
      end else begin
        acc_d   = acc_nxt;
        cnt_d   = cnt_q + NB_W'(1);
        range_d = drop_nz;
        zz_d    = zz_use;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_value     = out_value_q;
  assign bus.out_field     = out_raw_q[VALUE_W-1:3];
  assign bus.out_wire_type = out_raw_q[2:0];
  assign bus.out_nbytes    = out_nbytes_q;
  assign bus.out_err       = out_err_q;

endmodule
